snn_img_loader: RTL and testbench
=================================

// Module: snn_img_loader
// PURPOSE
// Upstream feeder for snn_core. Accepts a 28x28 1-bit image as a stream of
// packed bytes from the UART receiver and unpacks each byte into the 1-bit
// input-unit RAM, one pixel per cycle. After the last pixel it pulses start
// to snn_core, muxes the RAM address to the core, then latches the digit on done.
// PARAMETERS
// NUM_PIXELS  784  pixels per image; must be a multiple of 8 and <= 2**ADDR_WIDTH
// ADDR_WIDTH  10   input-unit RAM address width
// PORTS
// clk          in   1           system clock, all flops on posedge
// rst_n        in   1           asynchronous active-low reset
// rx_rdy       in   1           UART byte available; level, held until rx_clr_rdy
// rx_data      in   8           UART byte; bit0 = lowest-addressed pixel
// rx_clr_rdy   out  1           1-cycle acknowledge; byte captured this cycle
// ram_we       out  1           input-unit RAM write enable
// ram_addr     out  ADDR_WIDTH  input-unit RAM address (loader or core, muxed)
// ram_data     out  1           input-unit RAM write data (pixel)
// core_addr    in   ADDR_WIDTH  snn_core addr_input_unit
// start        out  1           1-cycle start pulse to snn_core
// core_done    in   1           snn_core done
// core_digit   in   4           snn_core digit
// digit_out    out  4           last classified digit, held until next result
// digit_vld    out  1           1-cycle pulse when digit_out updates
// busy         out  1           high in START and WAIT_DONE
// BEHAVIOUR
// - Reset: state IDLE, pix_cnt=0, bit_cnt=0, shift=0, digit_out=0; every output 0
//   (ram_addr=pix_cnt=0). Reset mid-load discards partial image; next byte -> addr 0.
// - States: IDLE, UNPACK, START, WAIT_DONE.
// - IDLE: if rx_rdy, rx_clr_rdy=1 combinationally that cycle, rx_data -> shift,
//   bit_cnt=0, go UNPACK. Else hold. ram_we=0, ram_addr=pix_cnt.
// - UNPACK (8 cycles): ram_we=1, ram_addr=pix_cnt, ram_data=shift[0]
//   (combinational); each edge: shift>>=1, pix_cnt++, bit_cnt++. After 8th write:
//   pix_cnt==NUM_PIXELS -> START, else -> IDLE. rx_clr_rdy=0 (rx_rdy ignored).
// - Per byte 9 cycles min (1 IDLE + 8 UNPACK); byte k bit i -> addr 8k+i.
// - START (1 cycle): start=1, ram_we=0, ram_addr=core_addr; pix_cnt cleared; -> WAIT_DONE.
// - WAIT_DONE: ram_we=0, ram_addr=core_addr, rx_rdy NOT acknowledged (backpressure).
//   On core_done=1: digit_out<=core_digit, digit_vld=1 next cycle for exactly 1
//   cycle, -> IDLE. core_done and rx_rdy together: digit latched, byte taken in
//   following IDLE cycle.
// - core_done outside WAIT_DONE ignored. start asserted exactly once per image.
// - pix_cnt width ADDR_WIDTH+1 internally if NUM_PIXELS==2**ADDR_WIDTH; no wrap.
// - busy = (state==START)|(state==WAIT_DONE); digit_out never changes except on latch.
// TESTING
// - 98 bytes 0xFF -> RAM addr 0..783 all 1, 784 ram_we cycles, start pulse exactly
//   once, in the cycle after the write to addr 783.
// - byte0=0x01, rest 0x00 -> addr0=1, addr1..783=0; byte1=0x80 -> addr15=1 only.
// - rx_rdy held during WAIT_DONE -> rx_clr_rdy stays 0 until done; that byte then
//   written to addr 0..7 of next image.
// - core_done with core_digit=4'h9 -> digit_out=9, digit_vld high 1 cycle, busy 0.
// - rst_n low after 50 bytes -> all outputs 0; next 98 bytes load addr 0..783, start once.
// - End-to-end with snn_core + ram, image of sample 9 packed LSB-first -> digit_out=9.

Source files
------------

// File: rtl/snn_img_loader.sv
// snn_img_loader: front-end feeder for snn_core.
//
// Takes a NUM_PIXELS-pixel 1-bit image as packed bytes from the UART receiver.
// Each byte is unpacked LSB-first into the input-unit RAM, one pixel per cycle.
// Once the last pixel is written, start is pulsed to snn_core, the RAM address
// is handed to the core, and the digit is latched when core_done arrives.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   rx_rdy, rx_data      UART byte available (level) and byte value
//   rx_clr_rdy           1-cycle acknowledge; byte captured this cycle
//   ram_we/addr/data     input-unit RAM write port (address muxed to core_addr when busy)
//   core_addr            snn_core input-unit address
//   start                1-cycle start pulse to snn_core
//   core_done/digit      snn_core completion and classified digit
//   digit_out/digit_vld  last classified digit and 1-cycle update pulse
//   busy                 core is running (START or WAIT_DONE)

module snn_img_loader #(
    parameter int unsigned NUM_PIXELS = 784,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_rdy,
    input  logic [7:0]            rx_data,
    output logic                  rx_clr_rdy,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_data,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    output logic                  start,
    input  logic                  core_done,
    input  logic [3:0]            core_digit,
    output logic [3:0]            digit_out,
    output logic                  digit_vld,
    output logic                  busy
);

    // One extra bit so a count equal to 2**ADDR_WIDTH is representable without wrapping.
    localparam int unsigned CntW = ADDR_WIDTH + 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(NUM_PIXELS);

    typedef enum logic [1:0] {
        StIdle,
        StUnpack,
        StStart,
        StWaitDone
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] pix_cnt_q, pix_cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [3:0]      digit_q, digit_d;
    logic            digit_vld_q, digit_vld_d;

    logic [CntW-1:0] pix_cnt_inc;

    assign pix_cnt_inc = pix_cnt_q + CntW'(1);

    // Next-state logic.
    always_comb begin
        state_d     = state_q;
        pix_cnt_d   = pix_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        digit_d     = digit_q;
        digit_vld_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (rx_rdy) begin
                    shift_d   = rx_data;
                    bit_cnt_d = 3'd0;
                    state_d   = StUnpack;
                end
            end
            StUnpack: begin
                shift_d   = {1'b0, shift_q[7:1]};
                pix_cnt_d = pix_cnt_inc;
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    state_d = (pix_cnt_inc == LastCnt) ? StStart : StIdle;
                end
            end
            StStart: begin
                pix_cnt_d = '0;
                state_d   = StWaitDone;
            end
            StWaitDone: begin
                // rx_rdy is deliberately left unacknowledged here so the UART
                // holds the next image's first byte until the core finishes.
                if (core_done) begin
                    digit_d     = core_digit;
                    digit_vld_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            pix_cnt_q   <= '0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'd0;
            digit_q     <= 4'd0;
            digit_vld_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pix_cnt_q   <= pix_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            digit_q     <= digit_d;
            digit_vld_q <= digit_vld_d;
        end
    end

    // Outputs decoded from registered state.
    always_comb begin
        busy       = (state_q == StStart) || (state_q == StWaitDone);
        start      = (state_q == StStart);
        rx_clr_rdy = (state_q == StIdle) && rx_rdy;
        ram_we     = (state_q == StUnpack);
        // shift_q is empty outside UNPACK, so ram_data is 0 whenever ram_we is low.
        ram_data   = shift_q[0];
        ram_addr   = busy ? core_addr : pix_cnt_q[ADDR_WIDTH-1:0];
        digit_out  = digit_q;
        digit_vld  = digit_vld_q;
    end

endmodule

// File: tb/tb_snn_img_loader.sv
// Directed bench for snn_img_loader: bytes are fed through the UART handshake,
// the expected RAM writes are queued as each byte is accepted, and a monitor
// pops and checks every observed write.

module tb_snn_img_loader;

    localparam int NPIX = 784;
    localparam int NBYTES = NPIX / 8;

    logic       clk;
    logic       rst_n;
    logic       rx_rdy;
    logic [7:0] rx_data;
    logic       rx_clr_rdy;
    logic       ram_we;
    logic [9:0] ram_addr;
    logic       ram_data;
    logic [9:0] core_addr;
    logic       start;
    logic       core_done;
    logic [3:0] core_digit;
    logic [3:0] digit_out;
    logic       digit_vld;
    logic       busy;

    snn_img_loader #(
        .NUM_PIXELS(784),
        .ADDR_WIDTH(10)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_rdy    (rx_rdy),
        .rx_data   (rx_data),
        .rx_clr_rdy(rx_clr_rdy),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data),
        .core_addr (core_addr),
        .start     (start),
        .core_done (core_done),
        .core_digit(core_digit),
        .digit_out (digit_out),
        .digit_vld (digit_vld),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] addr;
        logic       d;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   we_cnt = 0;
    int   start_cnt = 0;
    logic prev783 = 1'b0;

    logic mem [0:1023];
    logic img_exp [0:NPIX-1];
    int   exp_pix = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // RAM model.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_data;
    end

    // Write monitor / scoreboard consumer.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            prev783 = 1'b0;
        end else begin
            if (ram_we) begin
                we_cnt++;
                if (sb.size() == 0) begin
                    check("unexpected_write", 32'(ram_addr), 32'hffff_ffff);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("wr_addr", 32'(ram_addr), 32'(e.addr));
                    check("wr_data", 32'(ram_data), 32'(e.d));
                end
            end
            if (start) start_cnt++;
            if (start || prev783) check("start_after_783", 32'(start), 32'(prev783));
            if (busy) check("no_ack_while_busy", 32'(rx_clr_rdy), 32'd0);
            prev783 = ram_we && (ram_addr == 10'd783);
        end
    end

    // Called in the cycle rx_clr_rdy is high: queue the byte's writes and release rx_rdy.
    task automatic accept_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            sb.push_back({10'(exp_pix + i), b[i]});
            img_exp[exp_pix + i] = b[i];
        end
        exp_pix = (exp_pix + 8 == NPIX) ? 0 : exp_pix + 8;
        @(posedge clk);
        #1 rx_rdy = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        rx_rdy  = 1'b1;
        rx_data = b;
        #1;
        while (!rx_clr_rdy && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!rx_clr_rdy) begin
            check("ack_timeout", 32'd0, 32'd1);
            rx_rdy = 1'b0;
        end else begin
            accept_byte(b);
        end
    endtask

    task automatic check_image(input string tag);
        int diff;
        diff = 0;
        for (int i = 0; i < NPIX; i++) begin
            if (mem[i] !== img_exp[i]) diff++;
        end
        check(tag, 32'(diff), 32'd0);
    endtask

    task automatic pulse_done(input logic [3:0] d);
        @(negedge clk);
        core_done  = 1'b1;
        core_digit = d;
        @(posedge clk);
        #1 core_done = 1'b0;
        check("done_vld", 32'(digit_vld), 32'd1);
        check("done_digit", 32'(digit_out), 32'(d));
        check("done_busy", 32'(busy), 32'd0);
    endtask

    int we0;
    int st0;

    initial begin
        rst_n      = 1'b0;
        rx_rdy     = 1'b0;
        rx_data    = 8'd0;
        core_addr  = 10'h155;
        core_done  = 1'b0;
        core_digit = 4'd0;

        repeat (3) @(negedge clk);
        check("rst_ack", 32'(rx_clr_rdy), 32'd0);
        check("rst_we", 32'(ram_we), 32'd0);
        check("rst_addr", 32'(ram_addr), 32'd0);
        check("rst_data", 32'(ram_data), 32'd0);
        check("rst_start", 32'(start), 32'd0);
        check("rst_digit", 32'(digit_out), 32'd0);
        check("rst_vld", 32'(digit_vld), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        // Image 1: all ones.
        we0 = we_cnt;
        st0 = start_cnt;
        for (int k = 0; k < NBYTES; k++) send_byte(8'hFF);
        repeat (12) @(negedge clk);
        check("img1_we_cnt", 32'(we_cnt - we0), 32'd784);
        check("img1_start_cnt", 32'(start_cnt - st0), 32'd1);
        check("img1_busy", 32'(busy), 32'd1);
        check("img1_addr_mux", 32'(ram_addr), 32'h155);
        check("img1_sb_empty", 32'(sb.size()), 32'd0);
        check_image("img1_all_ones");

        pulse_done(4'h9);
        @(posedge clk);
        #1;
        check("vld_one_cycle", 32'(digit_vld), 32'd0);
        check("digit_held", 32'(digit_out), 32'd9);

        // core_done while idle must be ignored.
        @(negedge clk);
        core_done  = 1'b1;
        core_digit = 4'd5;
        @(posedge clk);
        #1 core_done = 1'b0;
        check("idle_done_vld", 32'(digit_vld), 32'd0);
        check("idle_done_digit", 32'(digit_out), 32'd9);

        // Image 2: only pixel 0 set.
        for (int k = 0; k < NBYTES; k++) send_byte((k == 0) ? 8'h01 : 8'h00);
        repeat (12) @(negedge clk);
        check_image("img2_image");
        check("img2_pix0", 32'(mem[0]), 32'd1);
        check("img2_pix1", 32'(mem[1]), 32'd0);
        pulse_done(4'h2);

        // Image 3: byte1 = 0x80, only pixel 15 set.
        for (int k = 0; k < NBYTES; k++) send_byte((k == 1) ? 8'h80 : 8'h00);
        repeat (12) @(negedge clk);
        check_image("img3_image");
        check("img3_pix15", 32'(mem[15]), 32'd1);
        check("img3_pix0", 32'(mem[0]), 32'd0);

        // Backpressure: byte offered during WAIT_DONE is held until core_done.
        @(negedge clk);
        rx_rdy  = 1'b1;
        rx_data = 8'hA5;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1 check("bp_no_ack", 32'(rx_clr_rdy), 32'd0);
        end
        @(negedge clk);
        core_done  = 1'b1;
        core_digit = 4'd3;
        #1 check("bp_no_ack_done_cycle", 32'(rx_clr_rdy), 32'd0);
        @(posedge clk);
        #1 core_done = 1'b0;
        check("bp_vld", 32'(digit_vld), 32'd1);
        check("bp_digit", 32'(digit_out), 32'd3);
        check("bp_ack_after_done", 32'(rx_clr_rdy), 32'd1);
        accept_byte(8'hA5);
        for (int k = 1; k < NBYTES; k++) send_byte(8'($urandom_range(0, 255)));
        repeat (12) @(negedge clk);
        check_image("img4_image");
        check("img4_byte0", 32'({mem[7], mem[6], mem[5], mem[4], mem[3], mem[2], mem[1], mem[0]}),
              32'h0A5);
        pulse_done(4'h7);

        // Reset mid-load discards the partial image.
        for (int k = 0; k < 50; k++) send_byte(8'($urandom_range(0, 255)));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_we", 32'(ram_we), 32'd0);
        check("mid_rst_addr", 32'(ram_addr), 32'd0);
        check("mid_rst_data", 32'(ram_data), 32'd0);
        check("mid_rst_digit", 32'(digit_out), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_start", 32'(start), 32'd0);
        exp_pix = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        we0 = we_cnt;
        st0 = start_cnt;
        for (int k = 0; k < NBYTES; k++) send_byte(8'($urandom_range(0, 255)));
        repeat (12) @(negedge clk);
        check("img5_we_cnt", 32'(we_cnt - we0), 32'd784);
        check("img5_start_cnt", 32'(start_cnt - st0), 32'd1);
        check_image("img5_image");
        pulse_done(4'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
